// File: rtl/thumb_imm_sequencer_if.sv
// rtl/thumb_imm_sequencer_if.sv - instruction-in / immediate-out handshake bundle for thumb_imm_sequencer
interface thumb_imm_sequencer_if;
   logic        inst_valid;
   logic        inst_ready;
   logic [15:0] inst;
   logic        flush;
   logic        imm_valid;
   logic        imm_ready;
   logic [31:0] imm_ex;
   logic [2:0]  imm_kind;
   logic        bl_err;

   modport master (
      output inst_valid, inst, flush, imm_ready,
      input  inst_ready, imm_valid, imm_ex, imm_kind, bl_err
   );

   modport slave (
      input  inst_valid, inst, flush, imm_ready,
      output inst_ready, imm_valid, imm_ex, imm_kind, bl_err
   );
endinterface

// File: rtl/thumb_imm_sequencer.sv
// rtl/thumb_imm_sequencer.sv - Thumb immediate-field decode/extend with 2-entry output buffer
// BL prefix/suffix pairing and bl_err are built only when THUMB_IMMSEQ_BL_EN is defined.
module thumb_imm_sequencer (
   input  logic                 clk,
   input  logic                 rst_n,
   thumb_imm_sequencer_if.slave bus
);
   logic [4:0]  op;
   logic        accept;
   logic        pop;
   logic        push;
   logic        base_valid;
   logic [31:0] base_imm;
   logic [2:0]  base_kind;
   logic        dec_valid;
   logic [31:0] dec_imm;
   logic [2:0]  dec_kind;
   logic [31:0] mem_imm [2];
   logic [2:0]  mem_kind [2];
   logic        wr_ptr;
   logic        rd_ptr;
   logic [1:0]  count;

   assign op             = bus.inst[15:11];
   assign bus.inst_ready = (count < 2'd2);
   assign accept         = bus.inst_valid && bus.inst_ready && !bus.flush;
   assign pop            = bus.imm_valid && bus.imm_ready && !bus.flush;
   assign push           = accept && dec_valid;

   // Single-word formats; BL halves fall through to "no output" here.
   always_comb begin
      base_valid = 1'b1;
      base_imm   = '0;
      base_kind  = 3'd0;
      if (op == 5'b00011) begin
         base_valid = bus.inst[10];
         base_kind  = 3'd0;
         base_imm   = {29'd0, bus.inst[8:6]};
      end else if (op[4:2] == 3'b000 || op == 5'b01111) begin
         base_kind = 3'd1;
         base_imm  = {27'd0, bus.inst[10:6]};
      end else if (op == 5'b01101) begin
         base_kind = 3'd2;
         base_imm  = {25'd0, bus.inst[10:6], 2'b00};
      end else if (op[4:2] == 3'b001) begin
         base_kind = 3'd3;
         base_imm  = {24'd0, bus.inst[7:0]};
      end else if (op == 5'b01001 || op[4:1] == 4'b1001) begin
         base_kind = 3'd4;
         base_imm  = {22'd0, bus.inst[7:0], 2'b00};
      end else if (op[4:1] == 4'b1101 && bus.inst[11:9] != 3'b111) begin
         base_kind = 3'd5;
         base_imm  = {{23{bus.inst[7]}}, bus.inst[7:0], 1'b0};
      end else if (op == 5'b11100) begin
         base_kind = 3'd6;
         base_imm  = {{20{bus.inst[10]}}, bus.inst[10:0], 1'b0};
      end else begin
         base_valid = 1'b0;
      end
   end

`ifdef THUMB_IMMSEQ_BL_EN
   typedef enum logic {IDLE = 1'b0, PREFIX = 1'b1} state_t;
   state_t      state;
   state_t      state_next;
   logic [10:0] hi;
   logic [10:0] hi_next;
   logic        is_prefix;
   logic        is_suffix;
   logic        err_next;
   logic        err_q;

   assign is_prefix = (op == 5'b11110);
   assign is_suffix = (op == 5'b11111);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         hi    <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_next;
         hi    <= hi_next;
         err_q <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      hi_next    = hi;
      if (bus.flush) begin
         state_next = IDLE;
      end else if (accept) begin
         state_next = is_prefix ? PREFIX : IDLE;
         if (is_prefix) hi_next = bus.inst[10:0];
      end
   end

   // Any word other than a suffix arriving while a prefix is held breaks the pair.
   always_comb begin
      dec_valid = base_valid;
      dec_imm   = base_imm;
      dec_kind  = base_kind;
      err_next  = accept && (is_suffix ? (state == IDLE) : (state == PREFIX));
      if (is_suffix) begin
         dec_valid = (state == PREFIX);
         dec_imm   = {{9{hi[10]}}, hi, bus.inst[10:0], 1'b0};
         dec_kind  = 3'd7;
      end
   end

   assign bus.bl_err = err_q;
`else
   assign dec_valid  = base_valid;
   assign dec_imm    = base_imm;
   assign dec_kind   = base_kind;
   assign bus.bl_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count       <= 2'd0;
         wr_ptr      <= 1'b0;
         rd_ptr      <= 1'b0;
         mem_imm[0]  <= '0;
         mem_imm[1]  <= '0;
         mem_kind[0] <= '0;
         mem_kind[1] <= '0;
      end else if (bus.flush) begin
         count  <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) begin
            mem_imm[wr_ptr]  <= dec_imm;
            mem_kind[wr_ptr] <= dec_kind;
            wr_ptr           <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: ;
         endcase
      end
   end

   assign bus.imm_valid = (count != 2'd0);
   assign bus.imm_ex    = mem_imm[rd_ptr];
   assign bus.imm_kind  = mem_kind[rd_ptr];
endmodule

// File: tb/tb_thumb_imm_sequencer.sv
// tb/tb_thumb_imm_sequencer.sv - vector table, directed corner sequences and random run against a queue model
module tb_thumb_imm_sequencer;
`ifdef THUMB_IMMSEQ_BL_EN
   localparam bit BL_EN = 1'b1;
`else
   localparam bit BL_EN = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   thumb_imm_sequencer_if bus();
   thumb_imm_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] inst;
      logic        v;
      logic [31:0] imm;
      logic [2:0]  kind;
   } vec_t;

   int          checks   = 0;
   int          failures = 0;
   logic [34:0] q[$];
   bit          m_prefix = 1'b0;
   logic [10:0] m_hi     = '0;
   bit          exp_err  = 1'b0;
   vec_t        vecs[16];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic push_exp(input logic [31:0] val, input logic [2:0] kind);
      q.push_back({kind, val});
   endtask

   // Reference decode: field value as a signed/unsigned integer times the format's scale.
   task automatic model_accept(input logic [15:0] w);
      logic [4:0]  op;
      int          s;
      logic [21:0] pair;
      op = w[15:11];
      if (BL_EN && op == 5'd31) begin
         if (m_prefix) begin
            pair = {m_hi, w[10:0]};
            s = int'(pair);
            if (m_hi[10]) s -= 4194304;
            push_exp(32'(s * 2), 3'd7);
         end else begin
            exp_err = 1'b1;
         end
         m_prefix = 1'b0;
         return;
      end
      if (BL_EN && op == 5'd30) begin
         if (m_prefix) exp_err = 1'b1;
         m_prefix = 1'b1;
         m_hi     = w[10:0];
         return;
      end
      if (m_prefix) exp_err = 1'b1;
      m_prefix = 1'b0;
      if (op == 5'd3) begin
         if (w[10]) push_exp(32'(int'(w[8:6])), 3'd0);
      end else if (op <= 5'd2 || op == 5'd15) begin
         push_exp(32'(int'(w[10:6])), 3'd1);
      end else if (op == 5'd13) begin
         push_exp(32'(int'(w[10:6]) * 4), 3'd2);
      end else if (op >= 5'd4 && op <= 5'd7) begin
         push_exp(32'(int'(w[7:0])), 3'd3);
      end else if (op == 5'd9 || op == 5'd18 || op == 5'd19) begin
         push_exp(32'(int'(w[7:0]) * 4), 3'd4);
      end else if ((op == 5'd26 || op == 5'd27) && w[11:8] < 4'd14) begin
         s = int'(w[7:0]);
         if (w[7]) s -= 256;
         push_exp(32'(s * 2), 3'd5);
      end else if (op == 5'd28) begin
         s = int'(w[10:0]);
         if (w[10]) s -= 2048;
         push_exp(32'(s * 2), 3'd6);
      end
   endtask

   // Entered just after a falling edge; returns at the next falling edge.
   task automatic cycle(input logic v, input logic [15:0] w, input logic fl, input logic rdy);
      bit acc;
      bit pop;
      bus.inst_valid = v;
      bus.inst       = w;
      bus.flush      = fl;
      bus.imm_ready  = rdy;
      #1;
      check("m_inst_ready", 32'(bus.inst_ready), 32'(q.size() < 2));
      check("m_imm_valid", 32'(bus.imm_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("m_imm_ex", bus.imm_ex, q[0][31:0]);
         check("m_imm_kind", 32'(bus.imm_kind), 32'(q[0][34:32]));
      end
      check("m_bl_err", 32'(bus.bl_err), 32'(exp_err));
      acc     = v && (q.size() < 2) && !fl;
      pop     = rdy && (q.size() != 0) && !fl;
      exp_err = 1'b0;
      if (fl) begin
         q.delete();
         m_prefix = 1'b0;
      end else begin
         if (pop) q.delete(0);
         if (acc) model_accept(w);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [15:0] rand_word();
      logic [15:0] w;
      w = 16'($urandom);
      case ($urandom_range(0, 7))
         0: w[15:11] = 5'b11110;
         1: w[15:11] = 5'b11111;
         2: w[15:11] = 5'b00011;
         3: w[15:12] = 4'b1101;
         default: ;
      endcase
      return w;
   endfunction

   initial begin
      vecs[0]  = '{16'h1D41, 1'b1, 32'h0000_0005, 3'd0};
      vecs[1]  = '{16'h0140, 1'b1, 32'h0000_0005, 3'd1};
      vecs[2]  = '{16'h1A00, 1'b0, 32'h0000_0000, 3'd0};
      vecs[3]  = '{16'h7FC0, 1'b1, 32'h0000_001F, 3'd1};
      vecs[4]  = '{16'h6FC0, 1'b1, 32'h0000_007C, 3'd2};
      vecs[5]  = '{16'h20FF, 1'b1, 32'h0000_00FF, 3'd3};
      vecs[6]  = '{16'h4880, 1'b1, 32'h0000_0200, 3'd4};
      vecs[7]  = '{16'h9A10, 1'b1, 32'h0000_0040, 3'd4};
      vecs[8]  = '{16'hD07F, 1'b1, 32'h0000_00FE, 3'd5};
      vecs[9]  = '{16'hD0FF, 1'b1, 32'hFFFF_FFFE, 3'd5};
      vecs[10] = '{16'hDE05, 1'b0, 32'h0000_0000, 3'd0};
      vecs[11] = '{16'hDF05, 1'b0, 32'h0000_0000, 3'd0};
      vecs[12] = '{16'hE7FE, 1'b1, 32'hFFFF_FFFC, 3'd6};
      vecs[13] = '{16'hE3FF, 1'b1, 32'h0000_07FE, 3'd6};
      vecs[14] = '{16'h4000, 1'b0, 32'h0000_0000, 3'd0};
      vecs[15] = '{16'hB000, 1'b0, 32'h0000_0000, 3'd0};

      bus.inst_valid = 1'b0;
      bus.inst       = '0;
      bus.flush      = 1'b0;
      bus.imm_ready  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("reset_imm_valid", 32'(bus.imm_valid), 32'd0);
      check("reset_imm_ex", bus.imm_ex, 32'd0);
      check("reset_imm_kind", 32'(bus.imm_kind), 32'd0);
      check("reset_bl_err", 32'(bus.bl_err), 32'd0);
      check("reset_inst_ready", 32'(bus.inst_ready), 32'd1);

      foreach (vecs[i]) begin
         cycle(1'b1, vecs[i].inst, 1'b0, 1'b0);
         check($sformatf("vec%0d_valid", i), 32'(bus.imm_valid), 32'(vecs[i].v));
         if (vecs[i].v) begin
            check($sformatf("vec%0d_imm", i), bus.imm_ex, vecs[i].imm);
            check($sformatf("vec%0d_kind", i), 32'(bus.imm_kind), 32'(vecs[i].kind));
         end
         cycle(1'b0, 16'h0, 1'b0, 1'b1);
      end

      cycle(1'b1, 16'hE7FE, 1'b0, 1'b0);
      cycle(1'b1, 16'hD0FF, 1'b0, 1'b0);
      check("order_first_imm", bus.imm_ex, 32'hFFFF_FFFC);
      check("order_first_kind", 32'(bus.imm_kind), 32'd6);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("order_second_imm", bus.imm_ex, 32'hFFFF_FFFE);
      check("order_second_kind", 32'(bus.imm_kind), 32'd5);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("order_drained", 32'(bus.imm_valid), 32'd0);

      cycle(1'b1, 16'hF000, 1'b0, 1'b1);
      check("bl_prefix_no_out", 32'(bus.imm_valid), 32'd0);
      cycle(1'b1, 16'hF802, 1'b0, 1'b1);
      check("bl_pos_valid", 32'(bus.imm_valid), 32'(BL_EN));
      check("bl_pos_imm", bus.imm_valid ? bus.imm_ex : 32'd0, BL_EN ? 32'h4 : 32'd0);
      cycle(1'b1, 16'hF7FF, 1'b0, 1'b1);
      check("bl_single_out", 32'(bus.imm_valid), 32'd0);
      cycle(1'b1, 16'hFFFE, 1'b0, 1'b1);
      check("bl_neg_imm", bus.imm_valid ? bus.imm_ex : 32'd0, BL_EN ? 32'hFFFF_FFFC : 32'd0);
      check("bl_neg_kind", bus.imm_valid ? 32'(bus.imm_kind) : 32'd0, BL_EN ? 32'd7 : 32'd0);
      check("bl_pair_no_err", 32'(bus.bl_err), 32'd0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);

      cycle(1'b1, 16'h2001, 1'b0, 1'b0);
      cycle(1'b1, 16'h2002, 1'b0, 1'b0);
      check("full_ready_low", 32'(bus.inst_ready), 32'd0);
      cycle(1'b1, 16'h2003, 1'b0, 1'b1);
      check("full_reopen", 32'(bus.inst_ready), 32'd1);
      check("full_head2", bus.imm_ex, 32'd2);
      cycle(1'b1, 16'h2003, 1'b0, 1'b1);
      check("full_head3", bus.imm_ex, 32'd3);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("full_drained", 32'(bus.imm_valid), 32'd0);

      cycle(1'b1, 16'hF800, 1'b0, 1'b1);
      check("err_suffix_idle", 32'(bus.bl_err), 32'(BL_EN));
      check("err_suffix_no_out", 32'(bus.imm_valid), 32'd0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("err_pulse_end", 32'(bus.bl_err), 32'd0);
      cycle(1'b1, 16'hF001, 1'b0, 1'b1);
      cycle(1'b0, 16'h0, 1'b1, 1'b1);
      check("err_no_flush_err", 32'(bus.bl_err), 32'd0);
      cycle(1'b1, 16'hF802, 1'b0, 1'b1);
      check("err_after_flush", 32'(bus.bl_err), 32'(BL_EN));
      cycle(1'b1, 16'hF001, 1'b0, 1'b1);
      cycle(1'b1, 16'h2007, 1'b0, 1'b1);
      check("err_broken_pair", 32'(bus.bl_err), 32'(BL_EN));
      check("err_broken_imm", bus.imm_ex, 32'd7);
      check("err_broken_kind", 32'(bus.imm_kind), 32'd3);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);

      cycle(1'b1, 16'h2011, 1'b0, 1'b0);
      cycle(1'b1, 16'h2012, 1'b0, 1'b0);
      bus.inst_valid = 1'b0;
      bus.imm_ready  = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("midrst_imm_valid", 32'(bus.imm_valid), 32'd0);
      check("midrst_imm_ex", bus.imm_ex, 32'd0);
      q.delete();
      m_prefix = 1'b0;
      exp_err  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_ready", 32'(bus.inst_ready), 32'd1);

      cycle(1'b1, 16'h2021, 1'b0, 1'b0);
      cycle(1'b1, 16'h2022, 1'b0, 1'b0);
      cycle(1'b1, 16'h2023, 1'b1, 1'b0);
      check("flush_full_empty", 32'(bus.imm_valid), 32'd0);
      cycle(1'b1, 16'h2031, 1'b0, 1'b0);
      cycle(1'b1, 16'h2032, 1'b1, 1'b1);
      check("flush_drop_word", 32'(bus.imm_valid), 32'd0);
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("flush_still_empty", 32'(bus.imm_valid), 32'd0);

      for (int n = 0; n < 3000; n++) begin
         cycle(1'($urandom_range(0, 3) != 0), rand_word(),
               1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
